// File: rtl/noc_packet_injector.sv
// Buffered NoC packet source: latches a descriptor, then serialises header, size and
// payload flits from a word FIFO onto the tx/credit/data local-port protocol.
module noc_packet_injector #(
  parameter int unsigned FLIT_SIZE  = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pkt_valid_i,
  output logic                 pkt_ready_o,
  input  logic [15:0]          pkt_target_i,
  input  logic [15:0]          pkt_len_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  input  logic [FLIT_SIZE-1:0] word_data_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 busy_o,
  output logic [31:0]          pkt_count_o
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        target_q, target_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FLIT_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic                 fifo_empty_c;
  logic                 fifo_full_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 tx_c;
  logic [FLIT_SIZE-1:0] data_c;

  // Extra pointer MSB distinguishes full from empty when indices match
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign push_c       = word_valid_i & ~fifo_full_c;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tx_c        = 1'b0;
    data_c      = '0;
    pop_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pkt_valid_i) begin
          target_d    = pkt_target_i;
          remaining_d = pkt_len_i;
          state_d     = HEADER;
        end
      end
      HEADER: begin
        tx_c   = 1'b1;
        data_c = FLIT_SIZE'(target_q);
        if (credit_i) state_d = SIZE;
      end
      SIZE: begin
        tx_c   = 1'b1;
        data_c = FLIT_SIZE'(remaining_q);
        if (credit_i) begin
          if (remaining_q == 16'd0) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 32'd1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        // An empty FIFO stalls the packet with tx low until a word arrives
        tx_c = ~fifo_empty_c;
        if (!fifo_empty_c) data_c = mem_q[rd_ptr_q[IDX_W-1:0]];
        if (tx_c && credit_i) begin
          pop_c       = 1'b1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      target_q    <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only read while the pointers say it holds data
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q[IDX_W-1:0]] <= word_data_i;
  end

  assign pkt_ready_o  = (state_q == IDLE);
  assign word_ready_o = ~fifo_full_c;
  assign tx_o         = tx_c;
  assign data_o       = data_c;
  assign busy_o       = (state_q != IDLE);
  assign pkt_count_o  = cnt_q;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Bench for noc_packet_injector: directed and random packets checked against a
// queue-based model of the expected flit stream and buffered payload words.
module tb_noc_packet_injector;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [15:0] pkt_target_i;
  logic [15:0] pkt_len_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [31:0] word_data_i;
  logic        tx_o;
  logic        credit_i;
  logic [31:0] data_o;
  logic        busy_o;
  logic [31:0] pkt_count_o;

  always #5 clk_i = ~clk_i;

  noc_packet_injector #(.FLIT_SIZE(32), .FIFO_DEPTH(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pkt_valid_i  (pkt_valid_i),
    .pkt_ready_o  (pkt_ready_o),
    .pkt_target_i (pkt_target_i),
    .pkt_len_i    (pkt_len_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .word_data_i  (word_data_i),
    .tx_o         (tx_o),
    .credit_i     (credit_i),
    .data_o       (data_o),
    .busy_o       (busy_o),
    .pkt_count_o  (pkt_count_o)
  );

  typedef struct {
    bit          is_pay;
    bit          last;
    logic [31:0] val;
  } ent_t;

  // Model: flits still owed for accepted packets, and words sitting in the FIFO
  ent_t        exp_q[$];
  logic [31:0] words_q[$];
  logic [31:0] push_q[$];
  int unsigned m_cnt = 0;

  int          tests = 0;
  int          fails = 0;
  bit          desc_pend = 1'b0;
  logic [15:0] d_target = '0;
  logic [15:0] d_len = '0;
  int          credit_mode = 0;
  bit          rand_push = 1'b0;
  int          cyc = 0;
  int          xfers = 0;
  int          pay_xfers = 0;
  int          busy_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample();
    bit          tx_e, rdy_e, wr_e;
    logic [31:0] d_e;
    ent_t        e;
    if (rst_i) begin
      exp_q.delete();
      words_q.delete();
      m_cnt = 0;
      chk("rst_tx", 32'(tx_o), 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_pkt_ready", 32'(pkt_ready_o), 32'd1);
      chk("rst_word_ready", 32'(word_ready_o), 32'd1);
      chk("rst_count", pkt_count_o, 32'd0);
      return;
    end
    rdy_e = (exp_q.size() == 0);
    wr_e  = (words_q.size() < 8);
    tx_e  = (exp_q.size() != 0) && (!exp_q[0].is_pay || words_q.size() != 0);
    d_e   = !tx_e ? 32'd0 : (exp_q[0].is_pay ? words_q[0] : exp_q[0].val);
    chk("tx", 32'(tx_o), 32'(tx_e));
    chk("data", data_o, d_e);
    chk("busy", 32'(busy_o), 32'(!rdy_e));
    chk("pkt_ready", 32'(pkt_ready_o), 32'(rdy_e));
    chk("word_ready", 32'(word_ready_o), 32'(wr_e));
    chk("count", pkt_count_o, m_cnt);
    if (!rdy_e) busy_cyc++;
    if (tx_e && credit_i) begin
      e = exp_q.pop_front();
      if (e.is_pay) begin
        words_q.delete(0);
        pay_xfers++;
      end
      if (e.last) m_cnt++;
      xfers++;
    end
    if (pkt_valid_i && rdy_e) begin
      e.is_pay = 1'b0; e.last = 1'b0; e.val = 32'(d_target);
      exp_q.push_back(e);
      e.last = (d_len == 16'd0); e.val = 32'(d_len);
      exp_q.push_back(e);
      for (int i = 0; i < int'(d_len); i++) begin
        e.is_pay = 1'b1; e.last = (i == int'(d_len) - 1); e.val = '0;
        exp_q.push_back(e);
      end
      desc_pend = 1'b0;
    end
    if (word_valid_i && wr_e) begin
      words_q.push_back(word_data_i);
      if (push_q.size() != 0) push_q.delete(0);
    end
  endtask

  task automatic drive();
    cyc++;
    case (credit_mode)
      0:       credit_i = 1'b1;
      1:       credit_i = ((cyc % 3) == 0);
      2:       credit_i = 1'($urandom_range(0, 1));
      default: credit_i = 1'b0;
    endcase
    word_valid_i = (push_q.size() != 0) && (!rand_push || ($urandom_range(0, 1) == 1));
    word_data_i  = (push_q.size() != 0) ? push_q[0] : 32'd0;
    pkt_valid_i  = desc_pend;
    pkt_target_i = d_target;
    pkt_len_i    = d_len;
  endtask

  task automatic cycle();
    @(negedge clk_i);
    sample();
    @(posedge clk_i);
    #1;
    drive();
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(exp_q.size() == 0 && !desc_pend && push_q.size() == 0) && n < max) begin
      cycle();
      n++;
    end
    tests++;
    assert (n < max) else begin
      fails++;
      $error("FAIL timeout_idle: waited %0d cycles, limit %0d", n, max);
    end
  endtask

  task automatic wait_payload(input int target, input int max);
    int n = 0;
    while (pay_xfers < target && n < max) begin
      cycle();
      n++;
    end
    tests++;
    assert (n < max) else begin
      fails++;
      $error("FAIL timeout_payload: got %0d payload flits, required %0d", pay_xfers, target);
    end
  endtask

  task automatic send(input logic [15:0] tgt, input logic [15:0] len);
    d_target  = tgt;
    d_len     = len;
    desc_pend = 1'b1;
  endtask

  initial begin
    rst_i        = 1'b1;
    pkt_valid_i  = 1'b0;
    pkt_target_i = '0;
    pkt_len_i    = '0;
    word_valid_i = 1'b0;
    word_data_i  = '0;
    credit_i     = 1'b0;

    // Reset then idle
    repeat (3) cycle();
    rst_i = 1'b0;
    cycle();
    chk("idle_tx", 32'(tx_o), 32'd0);
    chk("idle_pkt_ready", 32'(pkt_ready_o), 32'd1);
    chk("idle_word_ready", 32'(word_ready_o), 32'd1);
    chk("idle_count", pkt_count_o, 32'd0);

    // Basic packet with full credit
    credit_mode = 0;
    push_q = '{32'hA1, 32'hA2, 32'hA3};
    wait_idle(50);
    xfers = 0; busy_cyc = 0;
    send(16'h0102, 16'd3);
    wait_idle(50);
    cycle();
    chk("basic_xfers", 32'(xfers), 32'd5);
    chk("basic_busy_cycles", 32'(busy_cyc), 32'd5);
    chk("basic_busy_after", 32'(busy_o), 32'd0);
    chk("basic_count", pkt_count_o, 32'd1);

    // Same packet under 1,0,0 credit pattern
    credit_mode = 1;
    push_q = '{32'hA1, 32'hA2, 32'hA3};
    wait_idle(50);
    xfers = 0;
    send(16'h0102, 16'd3);
    wait_idle(100);
    cycle();
    chk("bp_xfers", 32'(xfers), 32'd5);
    chk("bp_count", pkt_count_o, 32'd2);

    // Zero-length packet
    credit_mode = 0;
    xfers = 0;
    send(16'h0303, 16'd0);
    wait_idle(50);
    cycle();
    chk("zero_xfers", 32'(xfers), 32'd2);
    chk("zero_pkt_ready", 32'(pkt_ready_o), 32'd1);
    chk("zero_count", pkt_count_o, 32'd3);

    // Fill FIFO with no credit; ninth word must be refused
    credit_mode = 3;
    for (int i = 0; i < 9; i++) push_q.push_back(32'hB0 + 32'(i));
    repeat (10) cycle();
    chk("full_word_ready", 32'(word_ready_o), 32'd0);
    push_q.delete();
    word_valid_i = 1'b0;
    credit_mode  = 0;
    pay_xfers    = 0;
    send(16'h0404, 16'd10);
    wait_payload(8, 100);
    repeat (4) cycle();
    chk("underflow_tx", 32'(tx_o), 32'd0);
    chk("underflow_busy", 32'(busy_o), 32'd1);
    push_q = '{32'hC9, 32'hCA};
    wait_idle(50);
    cycle();
    chk("fifo_pkt_count", pkt_count_o, 32'd4);

    // Reset in the middle of a payload
    push_q = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
    wait_idle(50);
    pay_xfers = 0;
    send(16'h0505, 16'd4);
    wait_payload(2, 50);
    rst_i = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx_o), 32'd0);
    chk("midrst_data", data_o, 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_count", pkt_count_o, 32'd0);
    repeat (2) cycle();
    rst_i = 1'b0;
    cycle();
    push_q = '{32'hE1, 32'hE2};
    send(16'h0606, 16'd2);
    wait_idle(50);
    cycle();
    chk("postrst_count", pkt_count_o, 32'd1);

    // Random packets, credit and word arrival
    credit_mode = 2;
    rand_push   = 1'b1;
    for (int p = 0; p < 15; p++) begin
      logic [15:0] len;
      len = 16'($urandom_range(0, 12));
      for (int i = 0; i < int'(len); i++) push_q.push_back($urandom);
      send(16'($urandom), len);
      wait_idle(1000);
    end
    cycle();
    chk("random_count", pkt_count_o, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Buffered packet source that drives a NoC local-port input, the same port the MA and application injectors drive, using the tx/credit/data flit protocol.
- Accepts a packet descriptor (target address and payload length) plus a stream of payload words.
- Serialises each packet as header flit, size flit, then payload flits, honouring NoC credit backpressure.
- Sits directly upstream of the many-core source port (ma_src/app_src input) in the simulation environment.

Parameters:
- FLIT_SIZE, 32, width of one flit and of one payload word.
- FIFO_DEPTH, 8, payload FIFO entries; must be a power of two and at least 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- pkt_valid_i  input  1  descriptor valid.
- pkt_ready_o  output  1  descriptor accept.
- pkt_target_i  input  16  destination router address.
- pkt_len_i  input  16  number of payload flits.
- word_valid_i  input  1  payload word valid.
- word_ready_o  output  1  payload FIFO not full.
- word_data_i  input  FLIT_SIZE  payload word.
- tx_o  output  1  flit valid toward the NoC.
- credit_i  input  1  NoC can accept a flit this cycle.
- data_o  output  FLIT_SIZE  flit data.
- busy_o  output  1  packet in progress.
- pkt_count_o  output  32  number of completed packets; wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync release): FSM in IDLE, FIFO empty, counters cleared. Outputs under reset:
  - pkt_ready_o=1, word_ready_o=1.
  - tx_o=0, data_o=0, busy_o=0, pkt_count_o=0.
- Reset asserted mid-packet aborts the packet immediately. Buffered words are discarded; no partial completion is counted.
- Flit transfer occurs only in a cycle with tx_o=1 and credit_i=1.
- While tx_o=1 and credit_i=0, data_o and tx_o hold stable. tx_o never drops without a transfer, except on reset.
- Descriptor handshake:
  - pkt_ready_o = (state==IDLE).
  - A descriptor is accepted on pkt_valid_i & pkt_ready_o.
  - On acceptance, target and length are latched and the FSM moves to HEADER the next cycle.
- FSM states and transitions:
  - IDLE: tx_o=0. Moves to HEADER on descriptor accept.
  - HEADER: tx_o=1, data_o = {zero-extend to FLIT_SIZE, target}. Moves to SIZE on transfer.
  - SIZE: tx_o=1, data_o = zero-extended len. On transfer: if len==0, return to IDLE and increment pkt_count_o; else go to PAYLOAD with remaining=len.
  - PAYLOAD: tx_o = FIFO not empty, data_o = FIFO head. Each transfer pops the FIFO and decrements remaining. The transfer at remaining==1 returns the FSM to IDLE and increments pkt_count_o.
- busy_o = (state != IDLE).
- data_o=0 whenever tx_o=0.
- Minimum packet length is 2+len cycles with credit_i held at 1.
- Back-to-back packets: a new descriptor is accepted in the IDLE cycle after the last flit, so there is a 1-cycle bubble between packets.
- Payload FIFO:
  - word_ready_o = !full. Push on word_valid_i & word_ready_o.
  - Push and pop in the same cycle are allowed; occupancy is then unchanged.
  - When full, pushes are refused; a pop in that cycle frees one slot for the next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap-around.
  - Words may be pushed in any state, including IDLE before their descriptor arrives. They are consumed strictly in order.
- A FIFO underflow inside PAYLOAD simply stalls: tx_o=0 until a word arrives. The stall has no timeout.
- pkt_len_i is treated as unsigned; 0xFFFF is valid.
- The block never checks that word supply matches len. Excess words remain buffered for the following packet.

Test Plan:
- Reset then idle: rst_i=1 for 3 cycles, then release -> tx_o=0, pkt_ready_o=1, word_ready_o=1, pkt_count_o=0.
- Basic packet: credit_i=1; push 0xA1,0xA2,0xA3; descriptor target=0x0102, len=3.
  - Flits 0x00000102, 0x00000003, 0xA1, 0xA2, 0xA3 on consecutive cycles.
  - busy_o falls after the last flit; pkt_count_o=1.
- Credit backpressure: same packet with credit_i toggling 1,0,0,1,...
  - Each flit is held stable through the 0-credit cycles; the sequence is identical to the basic packet.
  - Exactly 5 transfers.
- Zero-length packet: target=0x0303, len=0 -> only 0x00000303, 0x00000000 emitted; FSM returns to IDLE; count increments.
- FIFO full/underflow (FIFO_DEPTH=8):
  - Push 8 words with credit_i=0 -> word_ready_o=0 after the 8th; a 9th word is not accepted.
  - Descriptor len=10 -> after 8 payload flits tx_o=0 until words 9 and 10 are pushed, which are then emitted.
- Reset mid-packet: assert rst_i during the PAYLOAD of a len=4 packet after 2 payload flits.
  - Outputs return to reset values immediately; FIFO is empty; pkt_count_o=0.
  - The next packet is emitted correctly from its header.
